// File: rtl/tech_ff_pipe.sv
// tech_ff_pipe: WIDTH-bit, DEPTH-stage posedge register pipeline with
// valid/ready flow control, bubble collapsing, flush and occupancy count.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous reset, active-high (overrides flush and transfers)
//   flush      synchronous clear of every valid bit and the count
//   in_valid   d carries a word this cycle
//   in_ready   stage 0 can accept this cycle (combinational, no in_valid term)
//   d          input data
//   out_valid  q carries a word (registered)
//   out_ready  consumer accepts q this cycle
//   q          output data, last stage register
//   count      number of valid stages (registered, 0..DEPTH)

module tech_ff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_up_vld;
  logic [WIDTH-1:0] w_up_data [DEPTH];
  logic             w_push;
  logic             w_pop;

  // A stage may advance unless it and every stage after it hold a word
  // while the consumer stalls. Written as a reduction per stage instead of
  // a ripple so the chain has no self-referencing vector.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      assign w_adv[g] = out_ready | ~(&r_vld[DEPTH-1:g]);
      if (g == 0) begin : g_head
        assign w_up_vld[g]  = in_valid;
        assign w_up_data[g] = d;
      end else begin : g_body
        assign w_up_vld[g]  = r_vld[g-1];
        assign w_up_data[g] = r_data[g-1];
      end
    end
  endgenerate

  assign in_ready  = w_adv[0];
  assign out_valid = r_vld[DEPTH-1];
  assign q         = r_data[DEPTH-1];
  assign count     = r_count;

  assign w_push = in_valid & w_adv[0];
  assign w_pop  = r_vld[DEPTH-1] & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
      r_vld   <= '0;
      r_count <= '0;
    end else if (flush) begin
      // data registers keep their contents; only validity is dropped
      r_vld   <= '0;
      r_count <= '0;
    end else begin
      // data only loads on a real word so bubbles never toggle the flops
      for (int i = 0; i < DEPTH; i++) begin
        if (w_adv[i] && w_up_vld[i]) begin
          r_data[i] <= w_up_data[i];
        end
      end
      r_vld   <= (w_adv & w_up_vld) | (~w_adv & r_vld);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_tech_ff_pipe.sv
module tb_tech_ff_pipe;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] d = 8'h00;
  logic       in_ready, out_valid;
  logic [7:0] q;
  logic [2:0] count;

  // DEPTH=1 instance
  logic       d1_rst = 1'b1, d1_flush = 1'b0, d1_in_valid = 1'b0, d1_out_ready = 1'b0;
  logic [7:0] d1_d = 8'h00;
  logic       d1_in_ready, d1_out_valid;
  logic [7:0] d1_q;
  logic [0:0] d1_count;

  tech_ff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .out_valid(out_valid), .out_ready(out_ready), .q(q), .count(count)
  );

  tech_ff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) u_d1 (
    .clk(clk), .rst(d1_rst), .flush(d1_flush), .in_valid(d1_in_valid),
    .in_ready(d1_in_ready), .d(d1_d), .out_valid(d1_out_valid),
    .out_ready(d1_out_ready), .q(d1_q), .count(d1_count)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard: words pushed when accepted, popped when the DUT emits them
  logic [7:0] sb[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_q = 8'h00;

  task automatic cycle(input logic iv, input logic [7:0] dd, input logic ordy,
                       input logic fl, input logic rs);
    @(negedge clk);
    in_valid = iv; d = dd; out_ready = ordy; flush = fl; rst = rs;
    #2;
    if (!rs) begin
      if (prev_stall) begin
        chk("q_stable", 32'(q), 32'(prev_q));
        chk("ov_held", 32'(out_valid), 32'd1);
      end
      chk("count_vs_sb", 32'(count), 32'(sb.size()));
      if (out_valid && ordy && !fl) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: got q=0x%0h expected no word at %0t", q, $time);
        end else begin
          chk("sb_q", 32'(q), 32'(sb.pop_front()));
        end
      end
      if (iv && in_ready && !fl) sb.push_back(dd);
      if (fl) sb.delete();
      prev_stall = out_valid && !ordy && !fl;
      prev_q     = q;
    end else begin
      sb.delete();
      prev_stall = 1'b0;
    end
  endtask

  task automatic cycle1(input logic iv, input logic [7:0] dd, input logic ordy, input logic rs);
    @(negedge clk);
    d1_in_valid = iv; d1_d = dd; d1_out_ready = ordy; d1_rst = rs;
    #2;
  endtask

  typedef struct packed {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [2:0] cnt;
    logic [7:0] q;
  } vec_t;

  vec_t vec [13];

  initial begin
    // back-pressure sequence from an empty pipe
    vec[0]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 3'd0, 8'hA5};
    vec[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 3'd1, 8'hA5};
    vec[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 3'd2, 8'hA5};
    vec[3]  = '{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 3'd3, 8'hA5};
    vec[4]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10};
    vec[5]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10};
    vec[6]  = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b1, 3'd4, 8'h10};
    vec[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h11};
    vec[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 8'h11};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 8'h12};
    vec[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h13};
    vec[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 8'h14};
    vec[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h14};

    // reset
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_q", 32'(q), 32'hA5);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd1);

    // table-driven back-pressure
    for (int i = 0; i < 13; i++) begin
      cycle(vec[i].iv, vec[i].d, vec[i].ordy, 1'b0, 1'b0);
      chk($sformatf("vec%0d_ir", i), 32'(in_ready), 32'(vec[i].ir));
      chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vec[i].ov));
      chk($sformatf("vec%0d_cnt", i), 32'(count), 32'(vec[i].cnt));
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(vec[i].q));
    end

    // streaming with out_ready held high
    for (int k = 0; k < 12; k++) begin
      cycle(k < 8, 8'(k + 1), 1'b1, 1'b0, 1'b0);
      chk($sformatf("strm%0d_ov", k), 32'(out_valid), (k >= 4) ? 32'd1 : 32'd0);
      if (k >= 4) chk($sformatf("strm%0d_q", k), 32'(q), 32'(k - 3));
      if (k >= 4 && k <= 8) chk($sformatf("strm%0d_cnt", k), 32'(count), 32'd4);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("strm_drained", 32'(count), 32'd0);

    // bubble collapse: two words separated by idle cycles close up under stall
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bub_q0", 32'(q), 32'hAA);
    chk("bub_cnt", 32'(count), 32'd2);
    chk("bub_ir", 32'(in_ready), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bub_ov1", 32'(out_valid), 32'd1);
    chk("bub_q1", 32'(q), 32'hBB);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("bub_empty", 32'(out_valid), 32'd0);

    // flush with three words queued and a word offered the same cycle
    cycle(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("fl_pre_q", 32'(q), 32'hC1);
    chk("fl_pre_cnt", 32'(count), 32'd3);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk($sformatf("fl%0d_ov", k), 32'(out_valid), 32'd0);
      chk($sformatf("fl%0d_q", k), 32'(q), 32'hC1);
    end

    // reset while full and stalled, with flush and in_valid also high
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'(8'hD1 + k), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hD5, 1'b0, 1'b0, 1'b0);
    chk("full_ir", 32'(in_ready), 32'd0);
    chk("full_cnt", 32'(count), 32'd4);
    chk("full_q", 32'(q), 32'hD1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk($sformatf("mr%0d_ov", k), 32'(out_valid), 32'd0);
      chk($sformatf("mr%0d_q", k), 32'(q), 32'hA5);
      chk($sformatf("mr%0d_cnt", k), 32'(count), 32'd0);
    end

    // DEPTH=1 build: streaming with latency 1, then back-pressure
    cycle1(1'b0, 8'h00, 1'b0, 1'b1);
    cycle1(1'b0, 8'h00, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle1(k < 4, 8'(8'h31 + k), 1'b1, 1'b0);
      chk($sformatf("d1s%0d_ir", k), 32'(d1_in_ready), 32'd1);
      if (k >= 1 && k <= 4) begin
        chk($sformatf("d1s%0d_ov", k), 32'(d1_out_valid), 32'd1);
        chk($sformatf("d1s%0d_q", k), 32'(d1_q), 32'(8'h30 + k));
        chk($sformatf("d1s%0d_cnt", k), 32'(d1_count), 32'd1);
      end else begin
        chk($sformatf("d1s%0d_ov", k), 32'(d1_out_valid), 32'd0);
        chk($sformatf("d1s%0d_cnt", k), 32'(d1_count), 32'd0);
      end
      if (k == 0) chk("d1_rst_q", 32'(d1_q), 32'h5A);
    end
    cycle1(1'b1, 8'h41, 1'b0, 1'b0);
    chk("d1bp0_ir", 32'(d1_in_ready), 32'd1);
    cycle1(1'b1, 8'h42, 1'b0, 1'b0);
    chk("d1bp1_ir", 32'(d1_in_ready), 32'd0);
    chk("d1bp1_q", 32'(d1_q), 32'h41);
    chk("d1bp1_cnt", 32'(d1_count), 32'd1);
    cycle1(1'b1, 8'h42, 1'b1, 1'b0);
    chk("d1bp2_ir", 32'(d1_in_ready), 32'd1);
    chk("d1bp2_q", 32'(d1_q), 32'h41);
    cycle1(1'b0, 8'h00, 1'b1, 1'b0);
    chk("d1bp3_q", 32'(d1_q), 32'h42);
    chk("d1bp3_cnt", 32'(d1_count), 32'd1);
    cycle1(1'b0, 8'h00, 1'b1, 1'b0);
    chk("d1bp4_ov", 32'(d1_out_valid), 32'd0);
    chk("d1bp4_cnt", 32'(d1_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tech_ff_pipe.md
Name: tech_ff_pipe

Overview:
- Parametrised successor to the single-bit posedge technology flip-flop: a WIDTH-bit, DEPTH-stage register pipeline built from posedge flops, with valid/ready flow control, bubble collapsing, flush and occupancy count.
- Used by techmap tests and datapath retiming wherever a multi-cycle registered delay with back-pressure is needed.

Parameters:
- WIDTH, 8, data bits per stage (>=1).
- DEPTH, 4, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits).
- CW, $clog2(DEPTH+1), width of occupancy count (derived; not to be overridden).

Ports:
- clk  input  1  clock; all state updates on posedge only.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  d carries a word this cycle.
- in_ready  output  1  stage 0 can accept this cycle (combinational).
- d  input  WIDTH  input data.
- out_valid  output  1  q carries a word (registered).
- out_ready  input  1  consumer accepts q this cycle.
- q  output  WIDTH  output data = stage DEPTH-1 register.
- count  output  CW  number of valid stages (registered).

Behaviour:
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1], count register.
- Reset (rst=1 at posedge): all data <= RESET_VAL, all vld <= 0, count <= 0. Hence q=RESET_VAL, out_valid=0, count=0 the cycle after. rst overrides flush and any transfer; reset mid-stream discards all words.
- Advance chain (combinational): adv[DEPTH-1] = !vld[DEPTH-1] | out_ready; adv[i] = !vld[i] | adv[i+1]. in_ready = adv[0]. in_ready does not depend on in_valid (no combinational loop).
- On posedge with adv[i]=1: vld[i] <= incoming valid (in_valid for i=0, vld[i-1] otherwise); data[i] <= incoming data only if incoming valid = 1, else data[i] holds (no toggling on bubbles). With adv[i]=0: stage holds.
- Bubble collapse: an empty stage always accepts from upstream even when downstream is stalled; a stalled pipe fills to DEPTH words.
- Latency: word accepted at edge N (in_valid & in_ready) appears at out_valid/q after edge N+DEPTH-1 when no stalls (DEPTH=1: visible cycle after acceptance). Throughput 1 word/cycle with out_ready held high.
- Output transfer: out_valid & out_ready at a posedge. q stable while out_valid=1 and out_ready=0.
- Full: all vld=1 and out_ready=0 -> in_ready=0. Full with out_ready=1 -> in_ready=1; simultaneous push and pop, count unchanged.
- count: next = count + push - pop, push = in_valid & in_ready, pop = out_valid & out_ready; range 0..DEPTH, never wraps.
- flush=1 (rst=0): all vld <= 0, count <= 0; data registers hold; words pushed or popped in the same cycle are dropped / treated as not transferred for count. in_ready still reflects pre-flush state. No memory of flushed words.
- No X propagation: with in_valid=0 forever, q stays RESET_VAL after reset.

Test Plan:
- Reset: rst=1 for 2 cycles, RESET_VAL=8'hA5 -> q=8'hA5, out_valid=0, count=0, in_ready=1.
- Streaming: DEPTH=4, out_ready=1, push 8'h01..8'h08 on consecutive cycles -> 8'h01 valid on q 3 edges after acceptance (4th cycle), then one word per cycle in order, count steady at 4 during stream.
- Back-pressure: out_ready=0, push 6 words -> first 4 accepted, in_ready=0 after 4th, count=4, q=first word stable; raise out_ready 1 cycle -> one pop, one push same cycle, count stays 4.
- Bubble collapse: push word, idle 2 cycles, push word, out_ready=0 -> two words in stages 3 and 2 back-to-back, count=2; release -> popped on consecutive cycles.
- Flush: with 3 words queued, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, q unchanged, flushed-cycle input not emitted.
- Reset mid-operation: full stalled pipe, rst=1 with flush=1 and in_valid=1 -> count=0, q=RESET_VAL, no words ever emitted; DEPTH=1 build repeats streaming with latency 1.
